// File: rtl/exp_range_check_buf_pkg.sv
// Shared encodings for the exponent range-check buffer: result classes,
// FIFO state encoding and the overflow limit as a function of exponent width.
package exp_range_check_buf_pkg;

  localparam logic [1:0] CLS_NORMAL = 2'b00;
  localparam logic [1:0] CLS_OVF    = 2'b01;
  localparam logic [1:0] CLS_UDF    = 2'b10;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fifo_state_e;

  // Largest biased exponent that still encodes a finite number.
  function automatic int unsigned u_limit(input int unsigned w_exp);
    return (32'd1 << w_exp) - 32'd2;
  endfunction

endpackage

// File: rtl/exp_range_check_buf_classify.sv
// Combinational exponent classifier: underflow / overflow / normal with
// saturation of the result exponent.
module exp_classify
  import exp_range_check_buf_pkg::*;
#(
  parameter int W_EXP = 8
) (
  input  logic [W_EXP-1:0] exp_i,
  input  logic             cout_i,
  input  logic             borrow_i,
  output logic [W_EXP-1:0] exp_r_o,
  output logic [1:0]       class_o,
  output logic             comp_o
);

  localparam logic [W_EXP-1:0] U_LIMIT = W_EXP'(u_limit(W_EXP));

  assign comp_o = (exp_i > U_LIMIT);

  // A borrow means the true exponent went negative, so it outranks any carry.
  always_comb begin
    class_o = CLS_NORMAL;
    exp_r_o = exp_i;
    if (borrow_i) begin
      class_o = CLS_UDF;
      exp_r_o = '0;
    end else if (cout_i || comp_o) begin
      class_o = CLS_OVF;
      exp_r_o = '1;
    end else if (exp_i == '0) begin
      class_o = CLS_UDF;
      exp_r_o = '0;
    end
  end

endmodule

// File: rtl/exp_range_check_buf.sv
// Exponent range check with a 2-entry valid/ready output buffer, sticky
// overflow/underflow flags and a saturating overflow event counter.
module exp_range_check_buf
  import exp_range_check_buf_pkg::*;
#(
  parameter int W_EXP = 8,
  parameter int W_CNT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_EXP-1:0] exp,
  input  logic             cout_exp,
  input  logic             borrow_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_EXP-1:0] exp_r,
  output logic [1:0]       exp_class,
  output logic             overflow_cout,
  output logic             overflow_comp,
  input  logic             flag_clr,
  output logic             sticky_ovf,
  output logic             sticky_udf,
  output logic [W_CNT-1:0] ovf_count
);

  // Handshake: a transfer happens on a rising clk edge where valid && ready;
  // in_ready depends only on FIFO occupancy, never on out_ready.

  localparam logic [W_CNT-1:0] CNT_MAX = '1;

  logic [W_EXP-1:0] cls_exp_r;
  logic [1:0]       cls_class;
  logic             cls_comp;

  exp_classify #(.W_EXP(W_EXP)) u_classify (
    .exp_i    (exp),
    .cout_i   (cout_exp),
    .borrow_i (borrow_exp),
    .exp_r_o  (cls_exp_r),
    .class_o  (cls_class),
    .comp_o   (cls_comp)
  );

  fifo_state_e      state_q, state_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [W_EXP-1:0] mem_exp_q  [2];
  logic [1:0]       mem_cls_q  [2];
  logic             mem_cout_q [2];
  logic             mem_comp_q [2];
  logic             sticky_ovf_q, sticky_ovf_d;
  logic             sticky_udf_q, sticky_udf_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic             push, pop, ovf_pop, udf_pop;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign ovf_pop   = pop && (mem_cls_q[rd_ptr_q] == CLS_OVF);
  assign udf_pop   = pop && (mem_cls_q[rd_ptr_q] == CLS_UDF);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    unique case (state_q)
      ST_EMPTY: if (push) state_d = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_d = ST_FULL;
        else if (pop && !push) state_d = ST_EMPTY;
      end
      ST_FULL: if (pop) state_d = ST_ONE;
      default: state_d = ST_EMPTY;
    endcase
  end

  // A delivering pop wins over a coincident clear.
  always_comb begin
    sticky_ovf_d = flag_clr ? 1'b0 : sticky_ovf_q;
    sticky_udf_d = flag_clr ? 1'b0 : sticky_udf_q;
    cnt_d        = flag_clr ? '0 : cnt_q;
    if (ovf_pop) begin
      sticky_ovf_d = 1'b1;
      if (cnt_d != CNT_MAX) cnt_d = cnt_d + W_CNT'(1);
    end
    if (udf_pop) sticky_udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      sticky_ovf_q <= 1'b0;
      sticky_udf_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      sticky_ovf_q <= sticky_ovf_d;
      sticky_udf_q <= sticky_udf_d;
      cnt_q        <= cnt_d;
    end
  end

  // Storage needs no reset: every read is qualified by out_valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_exp_q[wr_ptr_q]  <= cls_exp_r;
      mem_cls_q[wr_ptr_q]  <= cls_class;
      mem_cout_q[wr_ptr_q] <= cout_exp;
      mem_comp_q[wr_ptr_q] <= cls_comp;
    end
  end

  assign exp_r         = out_valid ? mem_exp_q[rd_ptr_q]  : '0;
  assign exp_class     = out_valid ? mem_cls_q[rd_ptr_q]  : 2'b00;
  assign overflow_cout = out_valid ? mem_cout_q[rd_ptr_q] : 1'b0;
  assign overflow_comp = out_valid ? mem_comp_q[rd_ptr_q] : 1'b0;
  assign sticky_ovf    = sticky_ovf_q;
  assign sticky_udf    = sticky_udf_q;
  assign ovf_count     = cnt_q;

endmodule

// File: tb/tb_exp_range_check_buf.sv
// Bench for exp_range_check_buf: a single-precision instance with a 2-bit
// counter checked against a queue model, and a double-precision instance.
module tb_exp_range_check_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Single-precision instance, 2-bit counter
  logic       rst8 = 1'b1, in_valid8 = 1'b0, cout8 = 1'b0, borrow8 = 1'b0;
  logic       out_ready8 = 1'b0, flag_clr8 = 1'b0;
  logic [7:0] exp8 = '0;
  logic       in_ready8, out_valid8, ocout8, ocomp8, sovf8, sudf8;
  logic [7:0] exp_r8;
  logic [1:0] cls8, cnt8;

  exp_range_check_buf #(.W_EXP(8), .W_CNT(2)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .exp(exp8), .cout_exp(cout8), .borrow_exp(borrow8),
    .out_valid(out_valid8), .out_ready(out_ready8), .exp_r(exp_r8),
    .exp_class(cls8), .overflow_cout(ocout8), .overflow_comp(ocomp8),
    .flag_clr(flag_clr8), .sticky_ovf(sovf8), .sticky_udf(sudf8),
    .ovf_count(cnt8)
  );

  // Double-precision instance
  logic        rst11 = 1'b1, in_valid11 = 1'b0, cout11 = 1'b0, borrow11 = 1'b0;
  logic        out_ready11 = 1'b0, flag_clr11 = 1'b0;
  logic [10:0] exp11 = '0;
  logic        in_ready11, out_valid11, ocout11, ocomp11, sovf11, sudf11;
  logic [10:0] exp_r11;
  logic [1:0]  cls11;
  logic [7:0]  cnt11;

  exp_range_check_buf #(.W_EXP(11), .W_CNT(8)) dut11 (
    .clk(clk), .rst(rst11), .in_valid(in_valid11), .in_ready(in_ready11),
    .exp(exp11), .cout_exp(cout11), .borrow_exp(borrow11),
    .out_valid(out_valid11), .out_ready(out_ready11), .exp_r(exp_r11),
    .exp_class(cls11), .overflow_cout(ocout11), .overflow_comp(ocomp11),
    .flag_clr(flag_clr11), .sticky_ovf(sovf11), .sticky_udf(sudf11),
    .ovf_count(cnt11)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
  endtask

  // Reference model: a queue of at most two classified entries.
  typedef struct {
    int r;
    int cls;
    bit cout;
    bit comp;
  } ent_t;

  ent_t mq[$];
  bit   m_sovf, m_sudf;
  int   m_cnt;
  localparam int CNT_MAX8 = 3;

  function automatic ent_t ref_cls(input int e, input bit c, input bit b, input int w);
    ent_t x;
    int lim = (1 << w) - 2;
    x.cout = c;
    x.comp = (e > lim);
    if (b)                  begin x.cls = 2; x.r = 0; end
    else if (c || e > lim)  begin x.cls = 1; x.r = (1 << w) - 1; end
    else if (e == 0)        begin x.cls = 2; x.r = 0; end
    else                    begin x.cls = 0; x.r = e; end
    return x;
  endfunction

  task automatic check8();
    ent_t h;
    h.r = 0; h.cls = 0; h.cout = 0; h.comp = 0;
    if (mq.size() > 0) h = mq[0];
    chk("in_ready",      32'(in_ready8),  32'(mq.size() < 2));
    chk("out_valid",     32'(out_valid8), 32'(mq.size() > 0));
    chk("exp_r",         32'(exp_r8),     h.r);
    chk("exp_class",     32'(cls8),       h.cls);
    chk("overflow_cout", 32'(ocout8),     32'(h.cout));
    chk("overflow_comp", 32'(ocomp8),     32'(h.comp));
    chk("sticky_ovf",    32'(sovf8),      32'(m_sovf));
    chk("sticky_udf",    32'(sudf8),      32'(m_sudf));
    chk("ovf_count",     32'(cnt8),       m_cnt);
  endtask

  // Called at a falling edge; applies one cycle of inputs to dut8.
  task automatic step8(input bit v, input logic [7:0] e, input bit c, input bit b,
                       input bit ordy, input bit clr);
    bit push, pop;
    ent_t h;
    in_valid8 = v; exp8 = e; cout8 = c; borrow8 = b;
    out_ready8 = ordy; flag_clr8 = clr;
    push = v && (mq.size() < 2);
    pop  = ordy && (mq.size() > 0);
    @(posedge clk);
    if (clr) begin m_sovf = 0; m_sudf = 0; m_cnt = 0; end
    if (pop) begin
      h = mq.pop_front();
      if (h.cls == 1) begin
        m_sovf = 1;
        if (m_cnt < CNT_MAX8) m_cnt++;
      end
      if (h.cls == 2) m_sudf = 1;
    end
    if (push) mq.push_back(ref_cls(int'(e), c, b, 8));
    @(negedge clk);
    in_valid8 = 0; flag_clr8 = 0;
    check8();
  endtask

  task automatic reset8(input bit v, input bit clr);
    rst8 = 1; in_valid8 = v; exp8 = 8'h42; out_ready8 = 1; flag_clr8 = clr;
    @(posedge clk);
    mq.delete(); m_sovf = 0; m_sudf = 0; m_cnt = 0;
    @(negedge clk);
    rst8 = 0; in_valid8 = 0; flag_clr8 = 0;
    check8();
  endtask

  task automatic step11(input bit v, input logic [10:0] e, input bit ordy, input bit r);
    rst11 = r; in_valid11 = v; exp11 = e; cout11 = 0; borrow11 = 0;
    out_ready11 = ordy;
    @(posedge clk);
    @(negedge clk);
    rst11 = 0; in_valid11 = 0;
  endtask

  typedef struct {
    logic [7:0] e;
    bit         c;
    bit         b;
    logic [1:0] cls;
    logic [7:0] r;
    bit         comp;
  } vec8_t;

  vec8_t tab[9];

  initial begin
    tab[0] = '{8'h7F, 0, 0, 2'b00, 8'h7F, 0};
    tab[1] = '{8'hFF, 0, 0, 2'b01, 8'hFF, 1};
    tab[2] = '{8'h05, 0, 1, 2'b10, 8'h00, 0};
    tab[3] = '{8'h00, 0, 0, 2'b10, 8'h00, 0};
    tab[4] = '{8'hFE, 0, 0, 2'b00, 8'hFE, 0};
    tab[5] = '{8'h01, 0, 0, 2'b00, 8'h01, 0};
    tab[6] = '{8'h10, 1, 0, 2'b01, 8'hFF, 0};
    tab[7] = '{8'hFF, 1, 1, 2'b10, 8'h00, 1};
    tab[8] = '{8'h00, 1, 0, 2'b01, 8'hFF, 0};

    @(negedge clk);
    reset8(1, 1);

    // Classification table, one entry in flight, consumer always ready
    for (int i = 0; i < 9; i++) begin
      step8(1, tab[i].e, tab[i].c, tab[i].b, 1, 0);
      chk($sformatf("tab%0d_class", i), 32'(cls8),   32'(tab[i].cls));
      chk($sformatf("tab%0d_exp_r", i), 32'(exp_r8), 32'(tab[i].r));
      chk($sformatf("tab%0d_comp", i),  32'(ocomp8), 32'(tab[i].comp));
    end
    step8(0, 8'h00, 0, 0, 1, 0);

    // Single overflow delivery from a clean state
    reset8(0, 0);
    step8(1, 8'hFF, 0, 0, 1, 0);
    step8(0, 8'h00, 0, 0, 1, 0);
    chk("ovf_sticky_after_pop", 32'(sovf8), 32'd1);
    chk("ovf_count_after_pop",  32'(cnt8),  32'd1);

    // Backpressure: third push refused, head held, order kept
    reset8(0, 0);
    step8(1, 8'h11, 0, 0, 0, 0);
    step8(1, 8'h22, 0, 0, 0, 0);
    chk("bp_in_ready_full", 32'(in_ready8), 32'd0);
    step8(1, 8'h33, 0, 0, 0, 0);
    chk("bp_head_held", 32'(exp_r8), 32'h11);
    step8(0, 8'h00, 0, 0, 1, 0);
    chk("bp_second", 32'(exp_r8), 32'h22);
    step8(0, 8'h00, 0, 0, 1, 0);
    chk("bp_drained", 32'(out_valid8), 32'd0);

    // Counter saturation and clear colliding with an overflow pop
    reset8(0, 0);
    for (int i = 0; i < 4; i++) step8(1, 8'hFF, 0, 0, 1, 0);
    step8(0, 8'h00, 0, 0, 1, 0);
    chk("cnt_saturated", 32'(cnt8), 32'd3);
    step8(1, 8'hFF, 0, 0, 0, 0);
    step8(0, 8'h00, 0, 0, 1, 1);
    chk("clr_vs_pop_cnt",    32'(cnt8),  32'd1);
    chk("clr_vs_pop_sticky", 32'(sovf8), 32'd1);
    step8(0, 8'h00, 0, 0, 1, 1);
    chk("clr_alone_cnt", 32'(cnt8), 32'd0);

    // Reset with both entries in flight
    step8(1, 8'h44, 0, 0, 0, 0);
    step8(1, 8'h00, 0, 0, 0, 0);
    reset8(1, 0);
    step8(0, 8'h00, 0, 0, 1, 0);
    chk("rst_discard", 32'(out_valid8), 32'd0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      logic [7:0] e;
      case ($urandom_range(0, 4))
        0: e = 8'h00;
        1: e = 8'h01;
        2: e = 8'hFE;
        3: e = 8'hFF;
        default: e = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 99) == 0) reset8($urandom_range(0, 1) == 1, 0);
      else step8($urandom_range(0, 3) != 0, e, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0);
    end

    // Double-precision boundaries and reset while FULL
    step11(0, 11'h000, 1, 1);
    chk("d_rst_out_valid", 32'(out_valid11), 32'd0);
    chk("d_rst_in_ready",  32'(in_ready11),  32'd1);
    step11(1, 11'h7FE, 0, 0);
    chk("d_7fe_class", 32'(cls11),   32'd0);
    chk("d_7fe_exp_r", 32'(exp_r11), 32'h7FE);
    chk("d_7fe_comp",  32'(ocomp11), 32'd0);
    step11(1, 11'h7FF, 1, 0);
    chk("d_7ff_class", 32'(cls11),   32'd1);
    chk("d_7ff_exp_r", 32'(exp_r11), 32'h7FF);
    chk("d_7ff_comp",  32'(ocomp11), 32'd1);
    step11(0, 11'h000, 1, 0);
    chk("d_sticky_ovf", 32'(sovf11), 32'd1);
    chk("d_count",      32'(cnt11),  32'd1);
    step11(1, 11'h123, 0, 0);
    step11(1, 11'h456, 0, 0);
    chk("d_full_in_ready", 32'(in_ready11), 32'd0);
    chk("d_full_head",     32'(exp_r11),    32'h123);
    step11(1, 11'h321, 1, 1);
    chk("d_rst_full_out_valid", 32'(out_valid11), 32'd0);
    chk("d_rst_full_in_ready",  32'(in_ready11),  32'd1);
    chk("d_rst_full_sticky",    32'({sovf11, sudf11}), 32'd0);
    chk("d_rst_full_count",     32'(cnt11),  32'd0);
    chk("d_rst_full_exp_r",     32'(exp_r11), 32'd0);
    step11(0, 11'h000, 1, 0);
    chk("d_rst_discard", 32'(out_valid11), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
